// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage: req/ack handshake, fixed LATENCY, pipeline stall.
// Define DMEM_ERR_EN to add the misaligned-access `err` output and suppress misaligned accesses.
`timescale 1ns/1ps
module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        stall
`ifdef DMEM_ERR_EN
  ,
  output logic        err
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state;
  logic [3:0]      cnt;
  logic            lat_we;
  logic            lat_mis;
  logic [AW-1:0]   lat_idx;
  logic [31:0]     lat_wdata;
  logic [31:0]     mem [DEPTH];

  logic            req_mis;
  logic            commit;
  logic            cur_we;
  logic            cur_mis;
  logic [AW-1:0]   cur_idx;
  logic [31:0]     cur_wdata;
  logic            do_write;
  logic            do_read;
  logic            unused_addr_bits;

`ifdef DMEM_ERR_EN
  assign req_mis = (addr[1:0] != 2'b00);
`else
  assign req_mis = 1'b0;
`endif

  // Word index ignores the byte offset and every bit above the array, so addresses wrap.
  assign unused_addr_bits = ^{addr[31:AW+2], addr[1:0]};

  // A single-cycle access completes straight out of IDLE, so it must use the live inputs.
  always_comb begin
    commit    = 1'b0;
    cur_we    = lat_we;
    cur_mis   = lat_mis;
    cur_idx   = lat_idx;
    cur_wdata = lat_wdata;
    if (state == IDLE) begin
      commit    = req && (LATENCY == 1);
      cur_we    = we;
      cur_mis   = req_mis;
      cur_idx   = addr[AW+1:2];
      cur_wdata = wdata;
    end else if (state == BUSY) begin
      commit    = (cnt == 4'd1);
    end
  end

  assign do_write = commit && cur_we && !cur_mis;
  assign do_read  = commit && !cur_we;
  assign stall    = ((state == IDLE) && req) || (state == BUSY);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_mis   <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= '0;
      rdata     <= '0;
      ack       <= 1'b0;
`ifdef DMEM_ERR_EN
      err       <= 1'b0;
`endif
    end else begin
      ack <= commit;
`ifdef DMEM_ERR_EN
      err <= commit && cur_mis;
`endif
      if (do_read) rdata <= cur_mis ? '0 : mem[cur_idx];
      case (state)
        IDLE: if (req) begin
          lat_we    <= we;
          lat_mis   <= req_mis;
          lat_idx   <= addr[AW+1:2];
          lat_wdata <= wdata;
          cnt       <= 4'(LATENCY - 1);
          state     <= (LATENCY == 1) ? DONE : BUSY;
        end
        BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the array has no reset so it maps onto RAM; reset only blocks a pending store.
  always_ff @(posedge clk) begin
    if (rst && do_write) mem[cur_idx] <= cur_wdata;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder answering load/store requests issued by the MEMORY stage of the five-stage MIPS pipeline. It accepts one request at a time over a req/ack handshake, models a fixed access latency with a countdown FSM, and drives `stall` so the pipeline freezes until the access completes. It is the memory-side end of the MEM-stage `memread`/`memwrite` interface and replaces the zero-latency data array.

## Interface
- `DEPTH`, 256: number of 32-bit words; power of two.
- `LATENCY`, 2: cycles from request acceptance to `ack`; legal range 1..15.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-low reset.
- `req` input 1: request valid from MEM stage; held high until `ack`.
- `we` input 1: 1 = store (`memwrite`), 0 = load (`memread`).
- `addr` input 32: byte address (`alu_result`).
- `wdata` input 32: store data (`rdata2out`).
- `rdata` output 32: load data (`read_data`); registered.
- `ack` output 1: one-cycle completion pulse.
- `stall` output 1: freeze request to pipeline registers upstream of MEM/WB.
- `err` output 1: misaligned-access flag (only with `DMEM_ERR_EN`).

## Operation
- Word index = `addr[log2(DEPTH)+1:2]`; upper address bits are ignored, so addresses wrap modulo DEPTH*4.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: when `req`=1, latch `we`, `addr`, `wdata`; load counter with LATENCY-1; go to DONE if LATENCY=1, else go to BUSY.
  - BUSY: decrement the counter each cycle; when it reaches 0, go to DONE.
  - DONE: `ack`=1 for exactly this cycle; return to IDLE.
- Memory effects on the IDLE/BUSY→DONE edge:
  - Store: array word ← latched `wdata`.
  - Load: `rdata` ← array word.
- `rdata` holds its value until the next completed load; stores do not change it.
- `stall` = (IDLE & `req`) | BUSY, combinational from state and `req`; it is 0 in DONE.
- Protocol violation (`req` dropped during BUSY): the latched transaction still completes and `ack` still pulses.
- Back-to-back requests: a `req` that is high in the cycle after DONE is accepted in IDLE. There is one idle cycle between consecutive acks.
- Inputs changing after acceptance have no effect; only the latched copies are used.
- Reset (`rst`=0 at a clock edge):
  - Returns the FSM to IDLE, clears the counter and latches, forces `rdata`=0, `ack`=0, `err`=0.
  - A pending store is discarded.
  - Array contents are not modified by reset.

## Timing
- Request first seen high in cycle N (IDLE) → `ack` high in cycle N+LATENCY. Load data is valid in `rdata` from cycle N+LATENCY onward.
- `stall` is high during cycles N..N+LATENCY-1 and low in cycle N+LATENCY.
- Throughput: one access per LATENCY+1 cycles.
- Reset values: `rdata`=0, `ack`=0, `err`=0; `stall`=0 while `req`=0.

## Configuration
- `DMEM_ERR_EN` defined:
  - A request with `addr[1:0]`≠0 is flagged misaligned.
  - Misaligned store: the array is not written.
  - Misaligned load: `rdata` ← 0.
  - `err` pulses together with `ack`.
  - Latency is unchanged.
- `DMEM_ERR_EN` undefined: the `err` port is absent; `addr[1:0]` is ignored and every access is performed.

## Test plan
- Reset, then LATENCY=2: store `we`=1, `addr`=0x10, `wdata`=0xDEADBEEF. Required: `stall` high for 2 cycles, `ack` in cycle N+2. Then load from 0x10: `rdata`=0xDEADBEEF at its `ack`.
- LATENCY=1 back-to-back loads from 0x0 and 0x4 holding `req` high: acks one cycle after acceptance; the second request is accepted the cycle after the first `ack`; the two acks are 2 cycles apart.
- Wrap: DEPTH=256, store 0x12345678 to 0x400, then load from 0x000. Required: `rdata`=0x12345678.
- Reset mid-BUSY: LATENCY=4, store 0xAAAA5555 to 0x20, assert `rst`=0 at cycle N+2. Required: no `ack`; a later load from 0x20 returns the prior value, not 0xAAAA5555.
- `req` dropped in BUSY: `ack` still pulses at cycle N+LATENCY, and the store commits.
- With `DMEM_ERR_EN`, store 0x1 to 0x22: `err`=1 with `ack`, word 0x20 unchanged. A load from 0x23 returns `rdata`=0 and `err`=1.
